// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: word width, bubble encoding and
// the instruction-fetch state encoding.
package rv32i_pkg;

  localparam int          XLEN              = 32;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush > hold > load; when not loading,
// a bubble is inserted and the last PC is kept for debug visibility.
module if_id_reg
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= XLEN'(4);
      instr_q    <= NOP_INSTR;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (!hold_i) begin
      if (load_i) begin
        valid_q    <= 1'b1;
        pc_q       <= pc_i;
        pc_plus4_q <= pc_i + XLEN'(4);
        instr_q    <= instr_i;
      end else begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, drives the combinational instruction
// memory, and fills IF/ID with redirect/stall handling and fetch faults.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_BYTES = 2048,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        misalign_fault,
  output logic        range_fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         misalign_q;
  logic         range_q;
  logic         in_range;
  logic         load;

  // 33-bit sum so that pc near 2^32 cannot wrap back into range.
  assign in_range = ({1'b0, pc_q} + 33'd3) < 33'(IMEM_BYTES);
  assign load     = (state_q == ST_RUN) && in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_INIT;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_target[31:2], 2'b00};
      state_q    <= ST_RUN;
      misalign_q <= |redirect_target[1:0];
      range_q    <= 1'b0;
    end else if (stall) begin
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      case (state_q)
        ST_INIT: state_q <= ST_RUN;
        ST_RUN: begin
          if (in_range) begin
            pc_q <= pc_q + 32'd4;
          end else begin
            state_q <= ST_HALT;
            range_q <= 1'b1;
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (redirect_valid),
    .hold_i     (stall),
    .load_i     (load),
    .pc_i       (pc_q),
    .instr_i    (imem_rdata),
    .valid_o    (if_id_valid),
    .pc_o       (if_id_pc),
    .pc_plus4_o (if_id_pc_plus4),
    .instr_o    (if_id_instr)
  );

  assign imem_addr      = pc_q;
  assign misalign_fault = misalign_q;
  assign range_fault    = range_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-edge vectors push the
// expected post-edge outputs; a monitor pops and compares after each edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        misalign_fault;
  logic        range_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
    logic        rng;
    logic        chk_pc;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .misalign_fault  (misalign_fault),
    .range_fault     (range_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: distinct word per address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'd0) return 32'h0280_0213;
    return (a << 20) | 32'h0000_0093;
  endfunction

  assign imem_rdata = memw(imem_addr);

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", tag, field, act, req);
    end
  endtask

  // Monitor: compare one expectation after every edge that has one.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "imem_addr", imem_addr, e.addr);
      cmp(e.name, "valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      cmp(e.name, "instr", if_id_instr, e.instr);
      cmp(e.name, "misalign", {31'd0, misalign_fault}, {31'd0, e.mis});
      cmp(e.name, "range", {31'd0, range_fault}, {31'd0, e.rng});
      if (e.chk_pc) begin
        cmp(e.name, "if_id_pc", if_id_pc, e.pc);
        cmp(e.name, "if_id_pc4", if_id_pc_plus4, e.pc + 32'd4);
      end
      $display("txn %s: addr=%h v=%b pc=%h instr=%h mis=%b rng=%b",
               e.name, imem_addr, if_id_valid, if_id_pc, if_id_instr,
               misalign_fault, range_fault);
    end
  end

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic cyc(input string name, input logic rst, input logic stl,
                     input logic rv, input logic [31:0] tgt,
                     input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic e_mis, input logic e_rng, input logic e_chk);
    exp_t e;
    @(negedge clk);
    reset           = rst;
    stall           = stl;
    redirect_valid  = rv;
    redirect_target = tgt;
    e.name = name; e.addr = e_addr; e.valid = e_v; e.pc = e_pc;
    e.instr = e_instr; e.mis = e_mis; e.rng = e_rng; e.chk_pc = e_chk;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    // 1. reset held 3 edges, INIT cycle, first capture
    for (int i = 0; i < 3; i++)
      cyc("reset", 1, 0, 0, 0, 32'h0, 0, 32'h0, NOP, 0, 0, 1);
    cyc("init",  0, 0, 0, 0, 32'h0, 0, 32'h0, NOP, 0, 0, 1);
    cyc("cap0",  0, 0, 0, 0, 32'h4, 1, 32'h0, 32'h0280_0213, 0, 0, 1);

    // 2. free run
    cyc("run4",  0, 0, 0, 0, 32'h8,  1, 32'h4, memw(32'h4), 0, 0, 1);
    cyc("run8",  0, 0, 0, 0, 32'hC,  1, 32'h8, memw(32'h8), 0, 0, 1);
    cyc("run12", 0, 0, 0, 0, 32'h10, 1, 32'hC, memw(32'hC), 0, 0, 1);

    // 3. stall at pc=16 twice, then redirect to 4 under stall
    cyc("stall1", 0, 1, 0, 0, 32'h10, 1, 32'hC, memw(32'hC), 0, 0, 1);
    cyc("stall2", 0, 1, 0, 0, 32'h10, 1, 32'hC, memw(32'hC), 0, 0, 1);
    cyc("redir_stall", 0, 1, 1, 32'h4, 32'h4, 0, 32'h0, NOP, 0, 0, 0);
    cyc("after_redir", 0, 0, 0, 0, 32'h8, 1, 32'h4, memw(32'h4), 0, 0, 1);

    // 4. misaligned redirect
    cyc("mis_redir", 0, 0, 1, 32'h6, 32'h4, 0, 32'h0, NOP, 1, 0, 0);
    cyc("mis_clear", 0, 0, 0, 0, 32'h8, 1, 32'h4, memw(32'h4), 0, 0, 1);

    // 5. last legal word, then range fault and HALT
    cyc("redir_7fc", 0, 0, 1, 32'h7FC, 32'h7FC, 0, 32'h0, NOP, 0, 0, 0);
    cyc("cap_7fc",   0, 0, 0, 0, 32'h800, 1, 32'h7FC, memw(32'h7FC), 0, 0, 1);
    cyc("range",     0, 0, 0, 0, 32'h800, 0, 32'h0, NOP, 0, 1, 0);
    cyc("halt1",     0, 0, 0, 0, 32'h800, 0, 32'h0, NOP, 0, 0, 0);
    cyc("halt_stl",  0, 1, 0, 0, 32'h800, 0, 32'h0, NOP, 0, 0, 0);
    cyc("halt2",     0, 0, 0, 0, 32'h800, 0, 32'h0, NOP, 0, 0, 0);
    cyc("redir_0",   0, 0, 1, 32'h0, 32'h0, 0, 32'h0, NOP, 0, 0, 0);
    cyc("resume0",   0, 0, 0, 0, 32'h4, 1, 32'h0, 32'h0280_0213, 0, 0, 1);

    // 6. reset mid-stream with stall
    cyc("pre4",  0, 0, 0, 0, 32'h8, 1, 32'h4, memw(32'h4), 0, 0, 1);
    cyc("pre8",  0, 0, 0, 0, 32'hC, 1, 32'h8, memw(32'h8), 0, 0, 1);
    cyc("mid_reset", 1, 1, 0, 0, 32'h0, 0, 32'h0, NOP, 0, 0, 1);
    cyc("init2", 0, 0, 0, 0, 32'h0, 0, 32'h0, NOP, 0, 0, 1);
    cyc("cap0b", 0, 0, 0, 0, 32'h4, 1, 32'h0, 32'h0280_0213, 0, 0, 1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
